// File: rtl/hps_sprite_cmd_decoder.sv
// HPS Avalon-MM register decoder: stages sprite descriptors, commits them
// into a FWFT command FIFO and sequences frame-swap requests behind it.
module hps_sprite_cmd_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int REC_W      = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hps_chipselect,
    input  logic             hps_write,
    input  logic             hps_read,
    input  logic [2:0]       hps_address,
    input  logic [7:0]       hps_writedata,
    output logic [7:0]       hps_readdata,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_index,
    output logic [REC_W-1:0] cmd_record,
    output logic             swap_req,
    input  logic             swap_ack
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);

    typedef logic [REC_W+7:0] entry_t;

    logic [7:0]  stage_q [6];
    logic [7:0]  last_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]  count_q;
    logic        ovf_q;
    logic        swap_q;
    logic [7:0]  rdata_q;
    entry_t      mem_q [FIFO_DEPTH];

    logic        wr, rd, empty, full, pop, push, commit;
    logic        ovf_set, ovf_clr, swap_set, swap_clr;
    logic [REC_W-1:0] stage_rec;
    logic [7:0]  rd_mux;
    entry_t      head;

    assign wr     = hps_chipselect & hps_write;
    assign rd     = hps_chipselect & hps_read;
    assign empty  = (count_q == 4'd0);
    assign full   = (count_q == DEPTH_L);
    assign pop    = ~empty & cmd_ready;
    assign commit = wr & (hps_address == 3'd6);
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push   = commit & (~full | pop);

    assign ovf_set  = commit & ~push;
    assign ovf_clr  = wr & (hps_address == 3'd7) & hps_writedata[1];
    assign swap_set = wr & (hps_address == 3'd7) & hps_writedata[0];
    assign swap_clr = swap_ack & swap_req;

    assign stage_rec = {stage_q[5], stage_q[4], stage_q[3],
                        stage_q[2], stage_q[1], stage_q[0]};

    assign head       = mem_q[rd_ptr_q];
    assign cmd_valid  = ~empty;
    assign cmd_index  = head[REC_W+7:REC_W];
    assign cmd_record = head[REC_W-1:0];
    assign swap_req   = swap_q & empty;
    assign hps_readdata = rdata_q;

    always_comb begin
        rd_mux = 8'h00;
        case (hps_address)
            3'd6:    rd_mux = last_q;
            3'd7:    rd_mux = {count_q, ovf_q, swap_q, full, empty};
            default: rd_mux = stage_q[hps_address];
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {hps_writedata, stage_rec};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++) begin
                stage_q[i] <= 8'h00;
            end
            last_q   <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
            ovf_q    <= 1'b0;
            swap_q   <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            if (wr && hps_address < 3'd6) begin
                stage_q[hps_address] <= hps_writedata;
            end
            if (commit) begin
                last_q <= hps_writedata;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {3'd0, push} - {3'd0, pop};
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (swap_clr) begin
                swap_q <= 1'b0;
            end else if (swap_set) begin
                swap_q <= 1'b1;
            end
            // Registers above still hold pre-write values here
            if (rd) begin
                rdata_q <= rd_mux;
            end
        end
    end

endmodule
